// File: rtl/encoder8to3_pend.sv
// Pending-request 8-to-3 priority encoder with valid/ready output handshake.
// Requests are collected in a pending register, granted one per cycle in fixed
// priority order (bit 0 highest). A granted code is held stable until accepted,
// and repeat requests are counted in a saturating counter.
module encoder8to3_pend #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       req_i,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [2:0]       out_idx,
  output logic [7:0]       pending_o,
  output logic [CNT_W-1:0] merge_cnt
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e           state_q;
  logic [2:0]       out_idx_q;
  logic [7:0]       pending_q;
  logic [CNT_W-1:0] merge_cnt_q;

  logic       handshake;
  logic [7:0] grant_mask;
  logic [7:0] cand;
  logic       merge_hit;
  logic [2:0] cand_idx;

  // Lowest set index; bit 0 has the highest priority.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Grant mask, candidate (next pending) vector and merge detection.
  always_comb begin
    handshake  = (state_q == StHold) && out_ready;
    grant_mask = handshake ? (8'b1 << out_idx_q) : 8'h00;
    // A request on the bit being granted this cycle survives via the OR.
    cand       = (pending_q & ~grant_mask) | req_i;
    merge_hit  = |(req_i & pending_q & ~grant_mask);
    cand_idx   = lowest_idx(cand);
  end

  // Pending register: clear the granted bit, then merge in new requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 8'h00;
    end else begin
      pending_q <= cand;
    end
  end

  // Saturating count of requests landing on an already-pending bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      merge_cnt_q <= '0;
    end else if (merge_hit && (merge_cnt_q != {CNT_W{1'b1}})) begin
      merge_cnt_q <= merge_cnt_q + 1'b1;
    end
  end

  // Grant FSM: load a code from IDLE or after a handshake, otherwise hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      out_idx_q <= 3'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cand != 8'h00) begin
            out_idx_q <= cand_idx;
            state_q   <= StHold;
          end
        end
        StHold: begin
          if (handshake) begin
            if (cand != 8'h00) begin
              out_idx_q <= cand_idx;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign out_valid = (state_q == StHold);
  assign out_idx   = out_idx_q;
  assign pending_o = pending_q;
  assign merge_cnt = merge_cnt_q;

endmodule

// File: tb/tb_encoder8to3_pend.sv
// Directed bench for encoder8to3_pend: each step pushes its expected post-edge
// outputs into a scoreboard queue, which is popped and compared after the edge.
module tb_encoder8to3_pend;

  localparam int unsigned CntW = 8;

  logic            clk;
  logic            rst;
  logic [7:0]      req_i;
  logic            out_ready;
  logic            out_valid;
  logic [2:0]      out_idx;
  logic [7:0]      pending_o;
  logic [CntW-1:0] merge_cnt;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
    logic [7:0] pend;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   failures;

  encoder8to3_pend #(
    .CNT_W(CntW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_idx  (out_idx),
    .pending_o(pending_o),
    .merge_cnt(merge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus (entered 1 time unit after a rising edge).
  task automatic step(input string tag, input logic [7:0] req, input logic rdy,
                      input logic ev, input logic [2:0] ei, input logic [7:0] ep);
    exp_t e;
    req_i     = req;
    out_ready = rdy;
    sb_q.push_back('{valid: ev, idx: ei, pend: ep});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".valid"}, 32'(out_valid), 32'(e.valid));
    check({tag, ".idx"}, 32'(out_idx), 32'(e.idx));
    check({tag, ".pend"}, 32'(pending_o), 32'(e.pend));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_i     = 8'h00;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_i     = 8'h00;
    out_ready = 1'b0;

    // Reset values before any clock edge.
    #3;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.idx", 32'(out_idx), 32'd0);
    check("rst.pend", 32'(pending_o), 32'h00);
    check("rst.merge", 32'(merge_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request, one-cycle latency, then idle with empty pending.
    step("r26a", 8'h10, 1'b1, 1'b1, 3'd4, 8'h10);
    step("r26b", 8'h00, 1'b1, 1'b0, 3'd4, 8'h00);

    // Back-to-back grants in priority order.
    step("r27a", 8'hA5, 1'b1, 1'b1, 3'd0, 8'hA5);
    step("r27b", 8'h00, 1'b1, 1'b1, 3'd2, 8'hA4);
    step("r27c", 8'h00, 1'b1, 1'b1, 3'd5, 8'hA0);
    step("r27d", 8'h00, 1'b1, 1'b1, 3'd7, 8'h80);
    step("r27e", 8'h00, 1'b1, 1'b0, 3'd7, 8'h00);

    // Held code is not preempted by a higher-priority arrival.
    step("r28a", 8'h08, 1'b0, 1'b1, 3'd3, 8'h08);
    step("r28b", 8'h00, 1'b0, 1'b1, 3'd3, 8'h08);
    step("r28c", 8'h01, 1'b0, 1'b1, 3'd3, 8'h09);
    step("r28d", 8'h00, 1'b0, 1'b1, 3'd3, 8'h09);
    step("r28e", 8'h00, 1'b0, 1'b1, 3'd3, 8'h09);
    step("r28f", 8'h00, 1'b1, 1'b1, 3'd0, 8'h01);
    step("r28g", 8'h00, 1'b1, 1'b0, 3'd0, 8'h00);
    check("r28.merge", 32'(merge_cnt), 32'd0);

    // Re-request of the bit granted in the same cycle is kept and re-granted.
    step("r29a", 8'h40, 1'b0, 1'b1, 3'd6, 8'h40);
    step("r29b", 8'h40, 1'b1, 1'b1, 3'd6, 8'h40);
    check("r29.merge", 32'(merge_cnt), 32'd0);
    step("r29c", 8'h00, 1'b1, 1'b0, 3'd6, 8'h00);
    // out_ready while idle does nothing.
    step("r21", 8'h00, 1'b1, 1'b0, 3'd6, 8'h00);

    // Merge counter saturation.
    do_reset();
    step("r30a", 8'h04, 1'b0, 1'b1, 3'd2, 8'h04);
    check("r30.merge0", 32'(merge_cnt), 32'd0);
    for (int i = 1; i <= 300; i++) begin
      step("r30loop", 8'h04, 1'b0, 1'b1, 3'd2, 8'h04);
      if (i == 1) check("r30.merge1", 32'(merge_cnt), 32'd1);
      if (i == 254) check("r30.merge254", 32'(merge_cnt), 32'd254);
      if (i == 255) check("r30.merge255", 32'(merge_cnt), 32'd255);
    end
    check("r30.sat", 32'(merge_cnt), 32'd255);

    // Asynchronous reset in the middle of a hold.
    do_reset();
    step("r31a", 8'hF0, 1'b0, 1'b1, 3'd4, 8'hF0);
    step("r31b", 8'hF0, 1'b0, 1'b1, 3'd4, 8'hF0);
    check("r31.merge_pre", 32'(merge_cnt), 32'd1);
    #2;
    rst   = 1'b1;
    req_i = 8'hFF;
    #1;
    check("r31.valid", 32'(out_valid), 32'd0);
    check("r31.idx", 32'(out_idx), 32'd0);
    check("r31.pend", 32'(pending_o), 32'h00);
    check("r31.merge", 32'(merge_cnt), 32'd0);
    @(posedge clk);
    #1;
    check("r24.valid", 32'(out_valid), 32'd0);
    check("r24.pend", 32'(pending_o), 32'h00);
    rst = 1'b0;

    // First edge after reset behaves as idle with empty pending.
    step("r25a", 8'h02, 1'b0, 1'b1, 3'd1, 8'h02);
    step("r25b", 8'h00, 1'b1, 1'b0, 3'd1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/encoder8to3_pend.md
ENCODER8TO3_PEND -- requirements
Module: encoder8to3_pend

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 8, width of the merged-request counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port req_i, input, 8, per-line request pulses; bit k requests code k.
REQ-005 The block SHALL have port out_ready, input, 1, consumer accepts out_idx this cycle.
REQ-006 The block SHALL have port out_valid, output, 1, out_idx holds a valid encoded request.
REQ-007 The block SHALL have port out_idx, output, 3, binary code of the granted line (bit k -> 3'dk).
REQ-008 The block SHALL have port pending_o, output, 8, registered pending-request vector.
REQ-009 The block SHALL have port merge_cnt, output, CNT_W, saturating count of requests merged into an already-pending bit.

Function
REQ-010 The block SHALL keep an 8-bit pending register; handshake = out_valid & out_ready; grant_mask = one-hot(out_idx) on handshake, else 0.
REQ-011 The block SHALL update pending <= (pending & ~grant_mask) | req_i each cycle.
REQ-012 The block SHALL be a two-state FSM: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-013 Candidate vector SHALL be cand = (pending & ~grant_mask) | req_i, i.e. the next pending value.
REQ-014 IDLE: if cand != 0, load out_idx = lowest set index of cand and go HOLD; else stay IDLE, out_idx unchanged.
REQ-015 HOLD without handshake: out_idx and out_valid SHALL stay stable; new requests only accumulate in pending.
REQ-016 HOLD with handshake: if cand != 0, load lowest set index of cand and stay HOLD (back-to-back, one grant per cycle); else go IDLE.
REQ-017 Latency: req_i bit asserted in cycle N with block IDLE and nothing pending SHALL give out_valid=1, correct out_idx in cycle N+1.
REQ-018 Priority SHALL be fixed: bit 0 highest, bit 7 lowest; a lower-index request arriving during HOLD SHALL NOT preempt the held out_idx.
REQ-019 A req_i bit equal to the bit being granted in the same cycle SHALL leave that bit pending (request not lost) and be re-granted later.
REQ-020 merge_cnt SHALL increment by 1 per cycle in which any bit satisfies req_i[k] & pending[k] & ~grant_mask[k], saturating at 2^CNT_W-1.
REQ-021 out_ready while IDLE SHALL have no effect.
REQ-022 Pending bit for the held out_idx SHALL remain set in pending_o until the handshake cycle completes.

Reset
REQ-023 While rst=1, out_valid=0, out_idx=3'd0, pending=8'h00, merge_cnt=0, FSM=IDLE, independent of clk.
REQ-024 rst asserted mid-HOLD SHALL discard the held code and all pending requests; req_i sampled only after rst deasserts.
REQ-025 First rising edge after rst deassertion SHALL behave as IDLE with empty pending.

Verification
REQ-026 Reset, then req_i=8'h10 for one cycle, out_ready=1 -> next cycle out_valid=1, out_idx=3'd4; following cycle out_valid=0, pending_o=8'h00.
REQ-027 req_i=8'hA5 one cycle, out_ready=1 held -> out_idx sequence 0,2,5,7 on consecutive cycles, then out_valid=0.
REQ-028 HOLD on idx 3 with out_ready=0 for 4 cycles, req_i=8'h01 in cycle 2 -> out_idx stays 3 until ready, then 0 next.
REQ-029 HOLD on idx 6, req_i=8'h40 in handshake cycle -> next cycle out_valid=1, out_idx=6 again, merge_cnt unchanged.
REQ-030 Hold out_ready=0, pending bit 2 set, req_i=8'h04 for 300 cycles with CNT_W=8 -> merge_cnt saturates at 255.
REQ-031 rst asserted asynchronously mid-HOLD with pending=8'hF0 -> out_valid, pending_o, merge_cnt read 0 before next clk edge.
